// File: rtl/bin_to_decimal_pkg.sv
// Shared widths, FSM state and accumulator layout for bin_to_decimal.
// Imported by the converter top and its digit-adjust helper.
package bin_to_decimal_pkg;

    localparam int BIN_W       = 7;
    localparam int DIGIT_W     = 4;
    localparam int HUND_W      = 2;
    localparam int SHIFT_STEPS = 7;
    localparam int COUNT_W     = 3;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        UPDATE
    } state_t;

    typedef struct packed {
        logic [HUND_W-1:0]  hund;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more
// so the following left shift carries into the next decade.
module bcd_digit_adj
    import bin_to_decimal_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    assign adj = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_decimal.sv
// Free-running 7-bit binary to two-digit BCD converter (double dabble).
// Define BIN_TO_DECIMAL_CLAMP_EN to saturate 100..127 at 99.
module bin_to_decimal
    import bin_to_decimal_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BIN_W-1:0]   bin_i,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o
);

    state_t             state;
    logic [BIN_W-1:0]   sreg;
    bcd_t               acc;
    logic [COUNT_W-1:0] cnt;
    logic [DIGIT_W-1:0] tens_adj;
    logic [DIGIT_W-1:0] ones_adj;

    // Hundreds never exceeds 1, so it needs no correction stage.
    bcd_digit_adj u_adj_tens (
        .digit (acc.tens),
        .adj   (tens_adj)
    );

    bcd_digit_adj u_adj_ones (
        .digit (acc.ones),
        .adj   (ones_adj)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= LOAD;
            sreg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            tens_o <= '0;
            ones_o <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    sreg  <= bin_i;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {acc, sreg} <= {acc.hund, tens_adj, ones_adj, sreg} << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == COUNT_W'(SHIFT_STEPS - 1)) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
`ifdef BIN_TO_DECIMAL_CLAMP_EN
                    if (acc.hund != '0) begin
                        tens_o <= DIGIT_W'(9);
                        ones_o <= DIGIT_W'(9);
                    end else begin
                        tens_o <= acc.tens;
                        ones_o <= acc.ones;
                    end
`else
                    tens_o <= acc.tens;
                    ones_o <= acc.ones;
`endif
                    state <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_decimal.sv
// Self-checking bench for bin_to_decimal: directed timing cases plus
// random values checked against an arithmetic reference model.
module tb_bin_to_decimal;

    logic       clk;
    logic       rst;
    logic [6:0] bin;
    logic [3:0] tens;
    logic [3:0] ones;

    int n_tests = 0;
    int n_fail  = 0;

    bin_to_decimal dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bin_i  (bin),
        .tens_o (tens),
        .ones_o (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int v);
        int r;
        r = v;
        if (v >= 100) begin
`ifdef BIN_TO_DECIMAL_CLAMP_EN
            r = 99;
`else
            r = v - 100;
`endif
        end
        return {4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d,%0d expected %0d,%0d", tag,
                     got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int v;
        int vals[3];
        vals = '{5, 15, 42};

        rst = 1'b1;
        bin = '0;
        #2;
        repeat (3) begin
            @(negedge clk);
            check("rst_init", {tens, ones}, 8'h00);
        end
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(1);
            check("zero_run", {tens, ones}, model(0));
        end

        foreach (vals[k]) begin
            bin = 7'(vals[k]);
            tick(17);
            check($sformatf("settle_%0d", vals[k]), {tens, ones},
                  model(vals[k]));
            for (int i = 0; i < 133; i++) begin
                tick(1);
                check($sformatf("hold_%0d", vals[k]), {tens, ones},
                      model(vals[k]));
            end
        end

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", {tens, ones}, 8'h00);
        bin = 7'd99;
        repeat (5) begin
            @(negedge clk);
            check("rst_hold", {tens, ones}, 8'h00);
        end

        // First LOAD is the first edge after release; result 8 edges on
        bin = 7'd73;
        rst = 1'b0;
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("pre_73", {tens, ones}, 8'h00);
        tick(1);
        check("lat_73", {tens, ones}, model(73));

        bin = 7'd99;
        tick(9);
        check("val_99", {tens, ones}, model(99));

        // Change mid-SHIFT: 12 must commit before 34
        bin = 7'd12;
        tick(3);
        bin = 7'd34;
        tick(5);
        check("pre_12", {tens, ones}, model(99));
        tick(1);
        check("mid_12", {tens, ones}, model(12));
        tick(8);
        check("keep_12", {tens, ones}, model(12));
        tick(1);
        check("next_34", {tens, ones}, model(34));

        bin = 7'd127;
        tick(9);
        check("ovf_127", {tens, ones}, model(127));
        bin = 7'd100;
        tick(9);
        check("ovf_100", {tens, ones}, model(100));

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 127));
            bin = 7'(v);
            tick(17);
            check($sformatf("rand_%0d", v), {tens, ones}, model(v));
            tick(int'($urandom_range(0, 8)));
            check($sformatf("rand_hold_%0d", v), {tens, ones}, model(v));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
